// File: rtl/mem_datos_ls_pkg.sv
// Shared definitions for the load/store data memory.
// Contents:
//   F3_*          RV32I load/store Funct3 encodings
//   state_t       request-handling FSM states
//   access_fault  decides whether an access must be rejected
package mem_datos_ls_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // Rejects misaligned halfwords/words, reserved Funct3 codes, unsigned
  // stores and any byte address beyond the array (no wrap-around).
  function automatic logic access_fault(input logic [2:0]  f3,
                                        input logic        we,
                                        input logic [31:0] addr,
                                        input int unsigned addr_w);
    logic bad;
    bad = 1'b0;
    case (f3)
      F3_B:    bad = 1'b0;
      F3_BU:   bad = we;
      F3_H:    bad = addr[0];
      F3_HU:   bad = we | addr[0];
      F3_W:    bad = (addr[1:0] != 2'b00);
      default: bad = 1'b1;
    endcase
    if ((addr >> (addr_w + 2)) != 32'd0) begin
      bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

// File: rtl/mem_datos_ls_align.sv
// Byte-lane helper for the data memory (purely combinational).
// Ports:
//   st_funct3/st_offset/st_data -> st_lanes (byte write enables) and
//                                  st_word (store data replicated onto lanes)
//   ld_funct3/ld_offset/ld_word -> ld_data (selected lane, sign/zero extended)
module ls_align
  import mem_datos_ls_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_offset,
  input  logic [31:0] st_data,
  output logic [3:0]  st_lanes,
  output logic [31:0] st_word,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_offset,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Replicating the store data onto every lane lets the lane mask alone
  // decide which bytes land, so no barrel shifter is needed.
  always_comb begin
    st_lanes = 4'b0000;
    st_word  = st_data;
    case (st_funct3)
      F3_B, F3_BU: begin
        st_lanes = 4'b0001 << st_offset;
        st_word  = {4{st_data[7:0]}};
      end
      F3_H, F3_HU: begin
        st_lanes = st_offset[1] ? 4'b1100 : 4'b0011;
        st_word  = {2{st_data[15:0]}};
      end
      F3_W: st_lanes = 4'b1111;
      default: st_lanes = 4'b0000;
    endcase
  end

  always_comb begin
    ld_byte = ld_word[{ld_offset, 3'b000} +: 8];
    ld_half = ld_offset[1] ? ld_word[31:16] : ld_word[15:0];
    ld_data = ld_word;
    case (ld_funct3)
      F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data = {24'd0, ld_byte};
      F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_data = {16'd0, ld_half};
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/mem_datos_ls.sv
// RV32I data memory with fixed-latency request/Ready handshake.
// Ports:
//   CLK, RST                  clock, asynchronous active-high reset
//   Req, Write_EN, Funct3     request strobe (sampled in IDLE), store/load, size
//   ALUResult, WriteData      byte address, right-aligned store data
//   Ready, Busy, Fault        completion pulse, in-flight flag, rejected access
//   Read_Data                 extended load result, held until the next load
module mem_datos_ls
  import mem_datos_ls_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int LATENCY   = 1,
  parameter bit INIT_ZERO = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Req,
  input  logic        Write_EN,
  input  logic [2:0]  Funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic        Ready,
  output logic        Busy,
  output logic [31:0] Read_Data,
  output logic        Fault
);

  localparam int DEPTH = 2 ** ADDR_W;

  state_t      state_reg, state_next;
  logic [1:0]  cnt_reg, cnt_next;
  logic        accept, enter_done;

  logic [31:0] addr_reg, wdata_reg;
  logic [2:0]  f3_reg;
  logic        we_reg, fault_reg;

  logic        ld_valid_reg, ld_fault_reg;
  logic [2:0]  ld_f3_reg;
  logic [1:0]  ld_off_reg;

  logic        cur_sel, in_fault;
  logic [31:0] cur_addr, cur_wdata;
  logic [2:0]  cur_f3;
  logic        cur_we, cur_fault;
  logic        mem_we, mem_re;
  logic [ADDR_W-1:0] idx;

  logic [3:0]  st_lanes;
  logic [31:0] st_word, rd_word, ld_data;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    accept     = 1'b0;
    enter_done = 1'b0;
    case (state_reg)
      IDLE: begin
        if (Req) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            state_next = DONE;
            enter_done = 1'b1;
          end else begin
            state_next = WAIT;
            cnt_next   = 2'(LATENCY - 2);
          end
        end
      end
      WAIT: begin
        if (cnt_reg == 2'd0) begin
          state_next = DONE;
          enter_done = 1'b1;
        end else begin
          cnt_next = cnt_reg - 2'd1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign Ready     = (state_reg == DONE);
  assign Busy      = (state_reg != IDLE);
  assign Fault     = Ready & fault_reg;
  assign Read_Data = (ld_valid_reg && !ld_fault_reg) ? ld_data : 32'd0;

  // With LATENCY=1 the access completes on the accepting edge, so the
  // memory must act on the live inputs rather than the captured copy.
  assign in_fault  = access_fault(Funct3, Write_EN, ALUResult, ADDR_W);
  assign cur_sel   = (state_reg == IDLE);
  assign cur_addr  = cur_sel ? ALUResult : addr_reg;
  assign cur_wdata = cur_sel ? WriteData : wdata_reg;
  assign cur_f3    = cur_sel ? Funct3    : f3_reg;
  assign cur_we    = cur_sel ? Write_EN  : we_reg;
  assign cur_fault = cur_sel ? in_fault  : fault_reg;

  assign idx    = cur_addr[ADDR_W+1:2];
  assign mem_we = enter_done & cur_we & ~cur_fault;
  assign mem_re = enter_done & ~cur_we;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg    <= IDLE;
      cnt_reg      <= 2'd0;
      addr_reg     <= 32'd0;
      wdata_reg    <= 32'd0;
      f3_reg       <= 3'd0;
      we_reg       <= 1'b0;
      fault_reg    <= 1'b0;
      ld_valid_reg <= 1'b0;
      ld_fault_reg <= 1'b0;
      ld_f3_reg    <= 3'd0;
      ld_off_reg   <= 2'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        addr_reg  <= ALUResult;
        wdata_reg <= WriteData;
        f3_reg    <= Funct3;
        we_reg    <= Write_EN;
        fault_reg <= in_fault;
      end
      // Extension attributes travel alongside the registered RAM word.
      if (mem_re) begin
        ld_valid_reg <= 1'b1;
        ld_fault_reg <= cur_fault;
        ld_f3_reg    <= cur_f3;
        ld_off_reg   <= cur_addr[1:0];
      end
    end
  end

  // Byte-write-enable RAM; deliberately outside the reset domain so a
  // reset never disturbs its contents.
  generate
    if (INIT_ZERO) begin : g_mem_zero
      logic [3:0][7:0] mem [DEPTH] = '{default: '0};
      always_ff @(posedge CLK) begin
        for (int i = 0; i < 4; i++) begin
          if (mem_we && st_lanes[i]) mem[idx][i] <= st_word[8*i +: 8];
        end
        if (mem_re) rd_word <= mem[idx];
      end
    end else begin : g_mem_plain
      logic [3:0][7:0] mem [DEPTH];
      always_ff @(posedge CLK) begin
        for (int i = 0; i < 4; i++) begin
          if (mem_we && st_lanes[i]) mem[idx][i] <= st_word[8*i +: 8];
        end
        if (mem_re) rd_word <= mem[idx];
      end
    end
  endgenerate

  ls_align u_align (
    .st_funct3 (cur_f3),
    .st_offset (cur_addr[1:0]),
    .st_data   (cur_wdata),
    .st_lanes  (st_lanes),
    .st_word   (st_word),
    .ld_funct3 (ld_f3_reg),
    .ld_offset (ld_off_reg),
    .ld_word   (rd_word),
    .ld_data   (ld_data)
  );

endmodule

// File: tb/tb_mem_datos_ls.sv
// Bench for mem_datos_ls: one LATENCY=1 and one LATENCY=3 instance, a
// transaction-level byte-array model, and directed literal expectations.
module tb_mem_datos_ls;

  localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101;
  localparam int NBYTES = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req [2];
  logic        we_i [2];
  logic [2:0]  f3_i [2];
  logic [31:0] addr_i [2];
  logic [31:0] wd_i [2];
  logic        rdy [2];
  logic        bsy [2];
  logic        flt [2];
  logic [31:0] rdat [2];

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;
  int lat [2] = '{1, 3};

  mem_datos_ls #(.ADDR_W(8), .LATENCY(1), .INIT_ZERO(1'b1)) u_l1 (
    .CLK(clk), .RST(rst), .Req(req[0]), .Write_EN(we_i[0]), .Funct3(f3_i[0]),
    .ALUResult(addr_i[0]), .WriteData(wd_i[0]), .Ready(rdy[0]), .Busy(bsy[0]),
    .Read_Data(rdat[0]), .Fault(flt[0])
  );

  mem_datos_ls #(.ADDR_W(8), .LATENCY(3), .INIT_ZERO(1'b1)) u_l3 (
    .CLK(clk), .RST(rst), .Req(req[1]), .Write_EN(we_i[1]), .Funct3(f3_i[1]),
    .ALUResult(addr_i[1]), .WriteData(wd_i[1]), .Ready(rdy[1]), .Busy(bsy[1]),
    .Read_Data(rdat[1]), .Fault(flt[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  mmem [2][NBYTES];
  int          n = 0;
  logic        pend [2] = '{1'b0, 1'b0};
  int          e_at [2] = '{0, 0};
  logic        t_we [2];
  logic [2:0]  t_f3 [2];
  logic [31:0] t_a [2];
  logic [31:0] t_wd [2];
  logic        t_flt [2];
  logic [31:0] hold [2] = '{32'd0, 32'd0};

  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      B, BU:   return 1;
      H, HU:   return 2;
      W:       return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic mdl_fault(input logic w, input logic [2:0] f3, input logic [31:0] a);
    int sz;
    sz = size_of(f3);
    if (sz == 0) return 1'b1;
    if (w && (f3 == BU || f3 == HU)) return 1'b1;
    if ((a % sz) != 0) return 1'b1;
    if (longint'(a) + sz > NBYTES) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] mdl_load(input int d, input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < size_of(f3); i++) v[8*i +: 8] = mmem[d][a + i];
    if (f3 == B) v = {{24{v[7]}}, v[7:0]};
    if (f3 == H) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  task automatic mdl_op(input int d);
    logic [31:0] wd;
    wd = t_wd[d];
    if (t_flt[d]) begin
      if (!t_we[d]) hold[d] = 32'd0;
    end else if (t_we[d]) begin
      for (int i = 0; i < size_of(t_f3[d]); i++) mmem[d][t_a[d] + i] = wd[8*i +: 8];
    end else begin
      hold[d] = mdl_load(d, t_f3[d], t_a[d]);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NBYTES; i++) mmem[d][i] = 8'h00;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int d = 0; d < 2; d++) begin
          pend[d] = 1'b0;
          hold[d] = 32'd0;
        end
      end else begin
        n++;
        for (int d = 0; d < 2; d++) begin
          if (pend[d] && n == e_at[d] + 1) begin
            pend[d] = 1'b0;
          end else if (!pend[d] && req[d]) begin
            pend[d]  = 1'b1;
            e_at[d]  = n + lat[d] - 1;
            t_we[d]  = we_i[d];
            t_f3[d]  = f3_i[d];
            t_a[d]   = addr_i[d];
            t_wd[d]  = wd_i[d];
            t_flt[d] = mdl_fault(we_i[d], f3_i[d], addr_i[d]);
          end
          if (pend[d] && n == e_at[d]) mdl_op(d);
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        logic er;
        er = pend[d] && (n == e_at[d]);
        chk($sformatf("cyc%0d dut%0d busy", n, d), 32'(bsy[d]), 32'(pend[d]));
        chk($sformatf("cyc%0d dut%0d ready", n, d), 32'(rdy[d]), 32'(er));
        chk($sformatf("cyc%0d dut%0d fault", n, d), 32'(flt[d]), 32'(er && t_flt[d]));
        chk($sformatf("cyc%0d dut%0d rdata", n, d), rdat[d], hold[d]);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  // Called at a negedge with the DUT idle; returns at a negedge with it idle.
  task automatic txn(input int d, input logic w, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_f);
    int cyc;
    req[d] = 1'b1; we_i[d] = w; f3_i[d] = f3; addr_i[d] = a; wd_i[d] = wd;
    @(negedge clk);
    req[d] = 1'b0;
    cyc = 1;
    while (!rdy[d] && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    $display("[TB] dut%0d %s f3=%0d addr=0x%08h wdata=0x%08h -> rdata=0x%08h fault=%0b latency=%0d",
             d, w ? "store" : "load ", f3, a, wd, rdat[d], flt[d], cyc);
    chk($sformatf("dut%0d latency @0x%0h", d, a), cyc, lat[d]);
    chk($sformatf("dut%0d fault @0x%0h", d, a), 32'(flt[d]), 32'(exp_f));
    if (!w) chk($sformatf("dut%0d read_data @0x%0h", d, a), rdat[d], exp_rd);
    @(negedge clk);
  endtask

  logic [7:0] rmask, bmask;

  initial begin
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; we_i[d] = 1'b0; f3_i[d] = W; addr_i[d] = 32'd0; wd_i[d] = 32'd0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset dut%0d busy", d), 32'(bsy[d]), 32'd0);
      chk($sformatf("reset dut%0d ready", d), 32'(rdy[d]), 32'd0);
      chk($sformatf("reset dut%0d fault", d), 32'(flt[d]), 32'd0);
      chk($sformatf("reset dut%0d rdata", d), rdat[d], 32'd0);
    end
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    // LATENCY=1 instance
    txn(0, 1, W,  32'h004, 32'h11223344, 32'h0,        0);
    txn(0, 0, W,  32'h004, 32'h0,        32'h11223344, 0);
    txn(0, 1, B,  32'h005, 32'h000000AA, 32'h0,        0);
    txn(0, 0, W,  32'h004, 32'h0,        32'h1122AA44, 0);
    txn(0, 0, B,  32'h005, 32'h0,        32'hFFFFFFAA, 0);
    txn(0, 0, BU, 32'h005, 32'h0,        32'h000000AA, 0);
    txn(0, 1, H,  32'h006, 32'h00008001, 32'h0,        0);
    txn(0, 0, H,  32'h006, 32'h0,        32'hFFFF8001, 0);
    txn(0, 0, HU, 32'h006, 32'h0,        32'h00008001, 0);
    txn(0, 0, W,  32'h002, 32'h0,        32'h0,        1);
    txn(0, 1, H,  32'h003, 32'h0000BEEF, 32'h0,        1);
    txn(0, 0, W,  32'h000, 32'h0,        32'h00000000, 0);
    txn(0, 1, B,  32'h3FF, 32'h0000005A, 32'h0,        0);
    txn(0, 0, BU, 32'h3FF, 32'h0,        32'h0000005A, 0);
    txn(0, 0, W,  32'h3FC, 32'h0,        32'h5A000000, 0);
    txn(0, 0, B,  32'h400, 32'h0,        32'h0,        1);
    txn(0, 1, W,  32'h400, 32'hFFFFFFFF, 32'h0,        1);
    txn(0, 0, W,  32'h000, 32'h0,        32'h00000000, 0);
    txn(0, 0, 3'b011, 32'h000, 32'h0,    32'h0,        1);
    txn(0, 1, BU, 32'h000, 32'h0000FFFF, 32'h0,        1);
    txn(0, 0, H,  32'h006, 32'h0,        32'hFFFF8001, 0);

    // LATENCY=3 instance
    txn(1, 1, W,  32'h008, 32'h01020304, 32'h0,        0);
    txn(1, 0, W,  32'h008, 32'h0,        32'h01020304, 0);

    // Req held high: two accepts, each Ready three cycles after acceptance.
    req[1] = 1'b1; we_i[1] = 1'b0; f3_i[1] = W; addr_i[1] = 32'h008;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      rmask[k-1] = rdy[1];
      bmask[k-1] = bsy[1];
      if (k == 8) req[1] = 1'b0;
    end
    $display("[TB] dut1 held-Req load @0x008 -> ready_mask=0x%02h busy_mask=0x%02h", rmask, bmask);
    chk("held req ready pattern", 32'(rmask), 32'h44);
    chk("held req busy pattern", 32'(bmask), 32'h77);
    @(negedge clk);

    // Store aborted by reset while waiting.
    req[1] = 1'b1; we_i[1] = 1'b1; f3_i[1] = W; addr_i[1] = 32'h008; wd_i[1] = 32'hDEADBEEF;
    @(negedge clk);
    req[1] = 1'b0;
    #1 rst = 1'b1;
    #1;
    $display("[TB] dut1 store @0x008 aborted by reset -> busy=%0b ready=%0b fault=%0b rdata=0x%08h",
             bsy[1], rdy[1], flt[1], rdat[1]);
    chk("abort busy", 32'(bsy[1]), 32'd0);
    chk("abort ready", 32'(rdy[1]), 32'd0);
    chk("abort fault", 32'(flt[1]), 32'd0);
    chk("abort rdata", rdat[1], 32'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    txn(1, 0, W,  32'h008, 32'h0,        32'h01020304, 0);
    txn(1, 0, H,  32'h00A, 32'h0,        32'h00000102, 0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_datos_ls.md
MEM_DATOS_LS -- requirements
Module: mem_datos_ls

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set word-address bits; depth = 2**ADDR_W 32-bit words.
REQ-002 Parameter LATENCY, default 1, legal range 1..4, SHALL set cycles from request acceptance to Ready.
REQ-003 Parameter INIT_ZERO, default 1, SHALL zero the array at time 0 when 1 (simulation/FPGA init only).
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 RST  input  1  reset, asynchronous, active-high.
REQ-006 Req  input  1  request strobe; sampled only in IDLE.
REQ-007 Write_EN  input  1  1 = store, 0 = load; qualified by Req.
REQ-008 Funct3  input  3  RV32I access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 ALUResult  input  32  byte address.
REQ-010 WriteData  input  32  store data, right-aligned (bits [7:0] for B, [15:0] for H).
REQ-011 Ready  output  1  one-cycle completion pulse.
REQ-012 Busy  output  1  high from acceptance until the Ready cycle inclusive.
REQ-013 Read_Data  output  32  load result, extended per Funct3; valid while Ready high, held until next load completes.
REQ-014 Fault  output  1  high with Ready when the access was rejected.

Function
REQ-015 FSM states SHALL be IDLE, WAIT, DONE; reset state IDLE.
REQ-016 IDLE with Req=1 SHALL capture ALUResult, WriteData, Funct3, Write_EN and a Fault flag, then go to WAIT (LATENCY>1) or DONE (LATENCY=1).
REQ-017 WAIT SHALL count down LATENCY-1 cycles, then enter DONE; Ready rises exactly LATENCY cycles after the accepting edge.
REQ-018 DONE SHALL assert Ready for one cycle and return to IDLE; Req in DONE SHALL be ignored (no back-to-back acceptance).
REQ-019 Req outside IDLE SHALL be ignored with no side effect.
REQ-020 Fault SHALL be set at capture for: H/HU with addr[0]=1; W with addr[1:0]!=0; Funct3 011,110,111; or (store with Funct3 100/101); or addr[31:ADDR_W+2] nonzero.
REQ-021 A faulting access SHALL NOT modify memory; Read_Data SHALL be 0 for faulting loads.
REQ-022 Stores SHALL commit on the edge entering DONE, writing only the addressed byte lanes (B: 1 lane addr[1:0]; H: lanes addr[1]*2..+1; W: all 4).
REQ-023 Loads SHALL read the word at the edge entering DONE; B/H sign-extend, BU/HU zero-extend, W passes through; lane selected by addr[1:0].
REQ-024 A load from an address stored earlier SHALL return the stored value (no stale read; single outstanding request).
REQ-025 Highest valid address (DEPTH*4-1 for B) SHALL be accepted; wrap-around SHALL NOT occur (out-of-range faults).

Reset
REQ-026 RST SHALL asynchronously force state IDLE, counter 0, Ready 0, Busy 0, Fault 0, Read_Data 0.
REQ-027 RST SHALL NOT clear the memory array.
REQ-028 RST during WAIT SHALL abort the request; a pending store SHALL NOT be written.

Structure
REQ-029 Shared package SHALL hold Funct3 encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU) and FSM state encoding.
REQ-030 Byte-lane alignment/extension SHALL be a sub-module ls_align (combinational: lane mask, store shift, load extend).
REQ-031 Array SHALL be DEPTH x 4 bytes, inferable as byte-write-enable RAM.

Verification
REQ-032 LATENCY=1: store W 0x11223344 @0x04, then load W @0x04 -> Ready one cycle after each accept, Read_Data=0x11223344, Fault=0.
REQ-033 Store B 0xAA @0x05, load W @0x04 -> 0x1122AA44; load B @0x05 -> 0xFFFFFFAA; load BU -> 0x000000AA.
REQ-034 Store H 0x8001 @0x06, load H @0x06 -> 0xFFFF8001; load HU -> 0x00008001.
REQ-035 Load W @0x02 and store H @0x03 -> Fault=1 with Ready, memory @0x00 unchanged, Read_Data=0.
REQ-036 LATENCY=3: Req held high -> Ready at exactly 3 cycles, Req ignored while Busy, next accept in the cycle after Ready.
REQ-037 Store W 0xDEADBEEF @0x08, RST pulsed in WAIT -> outputs 0, subsequent load @0x08 returns prior contents (not 0xDEADBEEF).
